// File: rtl/fp_dot_accumulator.sv
// Streaming FP32 accumulator: sums products through a 4-cycle align/add/normalise path
// and emits the dot-product sum on the last term. Optional ReLU on out_data: FP_ACC_RELU_EN.
module fp_dot_accumulator #(
  parameter logic [31:0] BIAS_INIT = 32'h0000_0000,
  parameter int          CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the producer holds its payload until the transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t            r_state;
  state_t            w_next_state;

  logic [31:0]       r_acc;
  logic [31:0]       r_b;
  logic              r_last;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_out_data;
  logic [CNT_W-1:0]  r_out_count;

  logic              r_special;
  logic [31:0]       r_special_val;
  logic              r_sign_a;
  logic              r_sub;
  logic [7:0]        r_exp_a;
  logic [26:0]       r_sig_a;
  logic [26:0]       r_sig_b;
  logic [27:0]       r_sum;

  logic              w_accept;

  // ALIGN stage signals
  logic [7:0]        w_ea, w_eb;
  logic [22:0]       w_ma, w_mb;
  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic              w_special;
  logic [31:0]       w_special_val;
  logic [30:0]       w_key_a, w_key_b;
  logic              w_swap;
  logic [23:0]       w_sig_big, w_sig_small;
  logic [7:0]        w_exp_big, w_exp_small, w_diff;
  logic              w_sign_big;
  logic [26:0]       w_ext, w_mask, w_shifted;

  // ADD / NORM stage signals
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic [26:0]       w_norm;
  logic signed [9:0] w_e, w_e2;
  logic              w_rnd;
  logic [24:0]       w_m25;
  logic [22:0]       w_mant;
  logic              w_zero_sign;
  logic [31:0]       w_result;

  function automatic logic [4:0] f_lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = S_ALIGN;
      end
      S_ALIGN: w_next_state = S_ADD;
      S_ADD:   w_next_state = S_NORM;
      S_NORM:  w_next_state = r_last ? S_DONE : S_IDLE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign dbg_state = r_state;

  // ALIGN: classify specials, order by magnitude (subnormals read as zero), shift B into GRS.
  always_comb begin
    w_ea    = r_acc[30:23];
    w_eb    = r_b[30:23];
    w_ma    = r_acc[22:0];
    w_mb    = r_b[22:0];
    w_nan_a = (&w_ea) && (|w_ma);
    w_nan_b = (&w_eb) && (|w_mb);
    w_inf_a = (&w_ea) && !(|w_ma);
    w_inf_b = (&w_eb) && !(|w_mb);

    w_special     = 1'b0;
    w_special_val = 32'h0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_acc[31] != r_b[31]))) begin
      w_special     = 1'b1;
      w_special_val = QNAN;
    end else if (w_inf_a) begin
      w_special     = 1'b1;
      w_special_val = r_acc;
    end else if (w_inf_b) begin
      w_special     = 1'b1;
      w_special_val = r_b;
    end

    w_key_a = (w_ea == 8'd0) ? 31'd0 : r_acc[30:0];
    w_key_b = (w_eb == 8'd0) ? 31'd0 : r_b[30:0];
    w_swap  = (w_key_b > w_key_a);

    w_sig_big   = w_swap ? ((w_eb == 8'd0) ? 24'd0 : {1'b1, w_mb})
                         : ((w_ea == 8'd0) ? 24'd0 : {1'b1, w_ma});
    w_sig_small = w_swap ? ((w_ea == 8'd0) ? 24'd0 : {1'b1, w_ma})
                         : ((w_eb == 8'd0) ? 24'd0 : {1'b1, w_mb});
    w_exp_big   = w_swap ? w_eb : w_ea;
    w_exp_small = w_swap ? w_ea : w_eb;
    w_sign_big  = w_swap ? r_b[31] : r_acc[31];
    w_diff      = w_exp_big - w_exp_small;

    w_ext  = {w_sig_small, 3'b000};
    w_mask = ~(27'h7FF_FFFF << w_diff);
    if (w_diff >= 8'd26) w_shifted = {26'd0, |w_sig_small};
    else                 w_shifted = (w_ext >> w_diff) | {26'd0, |(w_ext & w_mask)};
  end

  always_comb begin
    if (r_sub) w_sum = {1'b0, r_sig_a - r_sig_b};
    else       w_sum = {1'b0, r_sig_a} + {1'b0, r_sig_b};
  end

  // NORM: carry-out shifts right, otherwise shift out leading zeros; then round to nearest even.
  always_comb begin
    w_lz = f_lzc27(r_sum[26:0]);
    if (r_sum[27]) begin
      w_norm = {r_sum[27:2], r_sum[1] | r_sum[0]};
      w_e    = $signed({2'b00, r_exp_a}) + 10'sd1;
    end else begin
      w_norm = r_sum[26:0] << w_lz;
      w_e    = $signed({2'b00, r_exp_a}) - $signed({5'b00000, w_lz});
    end
    w_rnd  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_m25  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    w_e2   = w_m25[24] ? (w_e + 10'sd1) : w_e;
    w_mant = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
    w_zero_sign = r_sub ? 1'b0 : r_sign_a;

    if (r_special)              w_result = r_special_val;
    else if (r_sum == 28'd0)    w_result = {w_zero_sign, 31'd0};
    else if (w_e2 >= 10'sd255)  w_result = {r_sign_a, 8'hFF, 23'd0};
    else if (w_e2 <= 10'sd0)    w_result = {r_sign_a, 31'd0};
    else                        w_result = {r_sign_a, w_e2[7:0], w_mant};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc         <= BIAS_INIT;
      r_b           <= 32'h0;
      r_last        <= 1'b0;
      r_count       <= '0;
      r_out_data    <= 32'h0;
      r_out_count   <= '0;
      r_special     <= 1'b0;
      r_special_val <= 32'h0;
      r_sign_a      <= 1'b0;
      r_sub         <= 1'b0;
      r_exp_a       <= 8'd0;
      r_sig_a       <= 27'd0;
      r_sig_b       <= 27'd0;
      r_sum         <= 28'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_b    <= in_data;
            r_last <= in_last;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_ALIGN: begin
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_sign_a      <= w_sign_big;
          r_sub         <= r_acc[31] ^ r_b[31];
          r_exp_a       <= w_exp_big;
          r_sig_a       <= {w_sig_big, 3'b000};
          r_sig_b       <= w_shifted;
        end
        S_ADD: r_sum <= w_sum;
        S_NORM: begin
          r_acc <= w_result;
          if (r_last) begin
            r_out_data  <= w_result;
            r_out_count <= r_count;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc   <= BIAS_INIT;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_ACC_RELU_EN
  assign out_data = r_out_data[31] ? 32'h0000_0000 : r_out_data;
`else
  assign out_data = r_out_data;
`endif
  assign out_count = r_out_count;

endmodule

// File: doc/fp_dot_accumulator.md
Name: fp_dot_accumulator

Overview:
- Downstream consumer of the single-precision IEEE-754 multiplier in the MNIST datapath.
- Accepts a stream of 32-bit products, one per handshake, and sums them into an internal FP32 accumulator using a multi-cycle adder.
- On the product tagged last, presents the neuron's dot-product sum. The accumulator is then re-seeded with the bias value for the next neuron.

Parameters:
- BIAS_INIT, 32'h00000000: FP32 value loaded into the accumulator at reset and after each output handshake.
- CNT_W, 10: width of the term counter. Default covers 784 MNIST pixels.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  32  FP32 product from the multiplier.
- in_last  input  1  marks the final term of the current sum.
- out_valid  output  1  out_data/out_count are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  FP32 accumulated sum.
- out_count  output  CNT_W  number of terms accepted for this sum.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: acc=BIAS_INIT, count=0, state=IDLE, in_ready=1, out_valid=0, out_data=0, out_count=0. Reset mid-operation aborts the partial sum with no output.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, register in_data and in_last, count+=1 (saturating at all-ones), go to ALIGN.
  - ALIGN: compare exponents and swap so the larger magnitude is A. Right-shift B's 24-bit significand by the exponent difference into guard/round/sticky. A shift of 26 or more leaves only sticky.
  - ADD: add or subtract significands according to the signs, 27-bit result.
  - NORM: normalise (carry-out right shift, or leading-zero left shift), round to nearest even, and write acc. Then go to DONE if last was registered, else IDLE.
  - DONE: out_valid=1 and out_data/out_count held stable. On out_ready: acc=BIAS_INIT, count=0, go to IDLE.
- Throughput: one product per 4 cycles. in_ready=0 in ALIGN/ADD/NORM/DONE. Result appears on the cycle after NORM of the last term.
- Subnormal handling: subnormal inputs and subnormal results are flushed to signed zero, matching the multiplier's underflow-to-zero behaviour.
- Zero results:
  - An exact-zero sum of opposite-signed operands gives +0.
  - (-0)+(-0) gives -0.
- Overflow: exponent overflow after rounding gives signed infinity (exponent FF, mantissa 0).
- Specials:
  - Any NaN operand gives canonical NaN 32'h7FC00000.
  - (+inf)+(-inf) gives 32'h7FC00000.
  - inf plus a finite value gives that inf.
  - Once acc is NaN or inf it is sticky until the output handshake.
- Simultaneous events:
  - in_valid is ignored while in_ready=0; the upstream must hold its data.
  - out_ready while out_valid=0 has no effect.
  - Counter saturation does not affect the arithmetic.

Optional Feature:
- Macro: FP_ACC_RELU_EN.
- When defined, out_data applies ReLU: any value with sign=1 (including -0, -inf and negative NaN patterns) is output as 32'h00000000. Canonical NaN passes unchanged. The internal acc is unaffected.
- When undefined, out_data equals acc exactly.

Test Plan:
- Basic sum: 3F800000, 40000000, 3F000000(last) -> out_data=40600000 (3.5), out_count=3, out_valid one cycle after the final NORM.
- Cancellation and sign: 3F800000, BF800000(last) -> 00000000. With FP_ACC_RELU_EN: C0000000 alone(last) -> 00000000; without the macro -> C0000000.
- Rounding: 3F800000 + 33800000(last) -> 3F800000 (tie to even). 3F800000 + 33800001(last) -> 3F800001. Subnormal 00000001 + 3F800000(last) -> 3F800000.
- Specials: 7F7FFFFF + 7F7FFFFF(last) -> 7F800000. 7F800000 + FF800000(last) -> 7FC00000. 7FC00001 + 3F800000(last) -> 7FC00000.
- Handshake: hold out_ready=0 for 5 cycles -> out_data/out_count stable and in_ready=0. Assert out_ready -> IDLE next cycle and the next sum starts from BIAS_INIT (run with BIAS_INIT=3F800000: single input 3F800000(last) -> 40000000).
- Reset mid-operation: assert reset during ADD of the second term -> in_ready=1, out_valid=0 next cycle. A following sum of 40400000(last) -> 40400000, count=1.
